// File: rtl/panxi_ifu_fetch_ctrl_pkg.sv
// Shared fetch-unit constants, fetch FSM encoding and a small alignment helper.
package panxi_ifu_fetch_ctrl_pkg;

    localparam int          PANXI_DW       = 32;
    localparam logic [31:0] PANXI_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] PANXI_NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/panxi_ifu_outbuf.sv
// Single-entry valid/ready IF/ID output register; a load beats flush and consume.
module panxi_ifu_outbuf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_pc,
    input  logic [DW-1:0] load_inst,
    input  logic          load_err,
    input  logic          flush,
    input  logic          rdy,
    output logic          vld,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] inst,
    output logic          err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            pc   <= '0;
            inst <= '0;
            err  <= 1'b0;
        end else if (load) begin
            vld  <= 1'b1;
            pc   <= load_pc;
            inst <= load_inst;
            err  <= load_err;
        end else if (flush || rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/panxi_ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one I-cache request in flight,
// applies ctrl redirects and drops responses that belong to a stale PC.
module panxi_ifu_fetch_ctrl
    import panxi_ifu_fetch_ctrl_pkg::*;
#(
    parameter int          DW       = PANXI_DW,
    parameter logic [DW-1:0] RESET_PC = DW'(PANXI_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_vld,
    input  logic [DW-1:0] redirect_pc,
    output logic          ic_req_vld,
    output logic [DW-1:0] ic_req_addr,
    input  logic          ic_req_rdy,
    input  logic          ic_rsp_vld,
    input  logic [DW-1:0] ic_rsp_inst,
    input  logic          ic_rsp_err,
    output logic          ifid_vld,
    output logic [DW-1:0] ifid_pc,
    output logic [DW-1:0] ifid_inst,
    output logic          ifid_err,
    input  logic          ifid_rdy,
    output logic          fetch_busy
);

    fetch_state_e  state_reg, state_next;
    logic [DW-1:0] pc_reg, pc_next;
    logic [DW-1:0] req_pc_reg, req_pc_next;
    logic          halt_pend_reg, halt_pend_next;

    logic          req_fire;
    logic          in_flight;
    logic          ob_load;
    logic [DW-1:0] ob_load_pc;
    logic [DW-1:0] ob_load_inst;
    logic          ob_load_err;
    logic          ob_flush;

    // Requests only when the output slot will be free by the time data returns.
    assign ic_req_vld  = (state_reg == ST_REQ) && (!ifid_vld || ifid_rdy);
    assign ic_req_addr = pc_reg;
    assign req_fire    = ic_req_vld && ic_req_rdy;
    assign fetch_busy  = (state_reg == ST_WAIT) || (state_reg == ST_DROP);

    // A request is still owed a response after this edge.
    assign in_flight = req_fire
                    || (((state_reg == ST_WAIT) || (state_reg == ST_DROP)) && !ic_rsp_vld);

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        req_pc_next    = req_pc_reg;
        halt_pend_next = halt_pend_reg;
        ob_load        = 1'b0;
        ob_load_pc     = req_pc_reg;
        ob_load_inst   = ic_rsp_inst;
        ob_load_err    = 1'b0;
        ob_flush       = 1'b0;

        unique case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + DW'(4);
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ic_rsp_vld) begin
                    ob_load = 1'b1;
                    if (ic_rsp_err) begin
                        ob_load_inst = DW'(PANXI_NOP_INST);
                        ob_load_err  = 1'b1;
                        state_next   = ST_HALT;
                    end else begin
                        state_next   = ST_REQ;
                    end
                end
            end
            ST_DROP: begin
                if (ic_rsp_vld) begin
                    state_next     = halt_pend_reg ? ST_HALT : ST_REQ;
                    halt_pend_next = 1'b0;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase

        // Redirect overrides whatever the state logic decided above.
        if (redirect_vld) begin
            pc_next  = redirect_pc;
            ob_flush = 1'b1;
            ob_load  = 1'b0;
            if (is_misaligned(redirect_pc[1:0])) begin
                ob_load        = 1'b1;
                ob_load_pc     = redirect_pc;
                ob_load_inst   = DW'(PANXI_NOP_INST);
                ob_load_err    = 1'b1;
                state_next     = in_flight ? ST_DROP : ST_HALT;
                halt_pend_next = in_flight;
            end else begin
                state_next     = in_flight ? ST_DROP : ST_REQ;
                halt_pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            req_pc_reg    <= '0;
            halt_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            req_pc_reg    <= req_pc_next;
            halt_pend_reg <= halt_pend_next;
        end
    end

    panxi_ifu_outbuf #(
        .DW (DW)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ob_load),
        .load_pc   (ob_load_pc),
        .load_inst (ob_load_inst),
        .load_err  (ob_load_err),
        .flush     (ob_flush),
        .rdy       (ifid_rdy),
        .vld       (ifid_vld),
        .pc        (ifid_pc),
        .inst      (ifid_inst),
        .err       (ifid_err)
    );

endmodule

// File: tb/tb_panxi_ifu_fetch_ctrl.sv
// Directed per-cycle vector table for the fetch sequencer plus a mid-run reset sequence.
module tb_panxi_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        ic_req_vld;
    logic [31:0] ic_req_addr;
    logic        ic_req_rdy;
    logic        ic_rsp_vld;
    logic [31:0] ic_rsp_inst;
    logic        ic_rsp_err;
    logic        ifid_vld;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_err;
    logic        ifid_rdy;
    logic        fetch_busy;

    panxi_ifu_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .ic_req_vld   (ic_req_vld),
        .ic_req_addr  (ic_req_addr),
        .ic_req_rdy   (ic_req_rdy),
        .ic_rsp_vld   (ic_rsp_vld),
        .ic_rsp_inst  (ic_rsp_inst),
        .ic_rsp_err   (ic_rsp_err),
        .ifid_vld     (ifid_vld),
        .ifid_pc      (ifid_pc),
        .ifid_inst    (ifid_inst),
        .ifid_err     (ifid_err),
        .ifid_rdy     (ifid_rdy),
        .fetch_busy   (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        qrdy;
        logic        sv;
        logic [31:0] si;
        logic        se;
        logic        ir;
        logic        qv;
        logic [31:0] qa;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iinst;
        logic        ierr;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic [31:0] rpc, input logic qrdy, input logic sv,
                       input logic [31:0] si, input logic se, input logic ir,
                       input logic qv, input logic [31:0] qa, input logic iv,
                       input logic [31:0] ipc, input logic [31:0] iinst, input logic ierr,
                       input logic busy);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.qrdy = qrdy; v.sv = sv; v.si = si; v.se = se; v.ir = ir;
        v.qv = qv; v.qa = qa; v.iv = iv; v.ipc = ipc; v.iinst = iinst; v.ierr = ierr; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rd, input logic [31:0] rpc, input logic qrdy, input logic sv,
                         input logic [31:0] si, input logic se, input logic ir);
        redirect_vld = rd;
        redirect_pc  = rpc;
        ic_req_rdy   = qrdy;
        ic_rsp_vld   = sv;
        ic_rsp_inst  = si;
        ic_rsp_err   = se;
        ifid_rdy     = ir;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //   rd rpc            qrdy sv si            se ir | qv qa            iv ipc           inst          err busy
        add(0, 0,             1,   0, 0,            0, 1,  0, 32'h8000_0000, 0, 0,            0,            0,  0); // 0 IDLE
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0000, 0, 0,            0,            0,  0); // 1
        add(0, 0,             1,   1, 32'hA000_0000, 0, 1, 0, 32'h8000_0004, 0, 0,            0,            0,  1); // 2
        for (int k = 0; k < 5; k++)
            add(0, 0,         1,   0, 0,            0, 0,  0, 32'h8000_0004, 1, 32'h8000_0000, 32'hA000_0000, 0, 0); // 3-7 stall
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0004, 1, 32'h8000_0000, 32'hA000_0000, 0, 0); // 8
        add(0, 0,             1,   1, 32'hA000_0001, 0, 1, 0, 32'h8000_0008, 0, 0,            0,            0,  1); // 9
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0008, 1, 32'h8000_0004, 32'hA000_0001, 0, 0); // 10
        add(0, 0,             1,   1, 32'hA000_0002, 1, 1, 0, 32'h8000_000C, 0, 0,            0,            0,  1); // 11 fault
        add(0, 0,             1,   0, 0,            0, 0,  0, 32'h8000_000C, 1, 32'h8000_0008, NOP,          1,  0); // 12 HALT
        add(0, 0,             1,   0, 0,            0, 1,  0, 32'h8000_000C, 1, 32'h8000_0008, NOP,          1,  0); // 13
        add(0, 0,             1,   0, 0,            0, 1,  0, 32'h8000_000C, 0, 0,            0,            0,  0); // 14
        add(1, 32'h8000_0040, 1,   0, 0,            0, 1,  0, 32'h8000_000C, 0, 0,            0,            0,  0); // 15
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0040, 0, 0,            0,            0,  0); // 16
        add(1, 32'h8000_0100, 1,   0, 0,            0, 1,  0, 32'h8000_0044, 0, 0,            0,            0,  1); // 17 WAIT redirect
        add(0, 0,             1,   1, BAD,          1, 1,  0, 32'h8000_0100, 0, 0,            0,            0,  1); // 18 DROP
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0100, 0, 0,            0,            0,  0); // 19
        add(0, 0,             1,   1, 32'hB000_0000, 0, 1, 0, 32'h8000_0104, 0, 0,            0,            0,  1); // 20
        add(1, 32'h8000_0200, 1,   0, 0,            0, 0,  0, 32'h8000_0104, 1, 32'h8000_0100, 32'hB000_0000, 0, 0); // 21 flush
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0200, 0, 0,            0,            0,  0); // 22
        add(1, 32'h8000_0300, 1,   1, BAD,          0, 1,  0, 32'h8000_0204, 0, 0,            0,            0,  1); // 23 rsp+redirect
        add(0, 0,             0,   0, 0,            0, 1,  1, 32'h8000_0300, 0, 0,            0,            0,  0); // 24
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h8000_0300, 0, 0,            0,            0,  0); // 25
        add(0, 0,             1,   1, 32'hC000_0000, 0, 1, 0, 32'h8000_0304, 0, 0,            0,            0,  1); // 26
        add(1, 32'h8000_0102, 1,   0, 0,            0, 1,  1, 32'h8000_0304, 1, 32'h8000_0300, 32'hC000_0000, 0, 0); // 27 misaligned
        add(0, 0,             1,   1, BAD,          1, 0,  0, 32'h8000_0102, 1, 32'h8000_0102, NOP,          1,  1); // 28 DROP
        add(0, 0,             1,   0, 0,            0, 0,  0, 32'h8000_0102, 1, 32'h8000_0102, NOP,          1,  0); // 29 HALT
        add(1, 32'hFFFF_FFFC, 1,   0, 0,            0, 0,  0, 32'h8000_0102, 1, 32'h8000_0102, NOP,          1,  0); // 30
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'hFFFF_FFFC, 0, 0,            0,            0,  0); // 31
        add(0, 0,             1,   1, 32'hD000_0000, 0, 1, 0, 32'h0000_0000, 0, 0,            0,            0,  1); // 32 wrap
        add(0, 0,             0,   0, 0,            0, 1,  1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hD000_0000, 0, 0); // 33
        add(0, 0,             1,   0, 0,            0, 1,  1, 32'h0000_0000, 0, 0,            0,            0,  0); // 34

        @(negedge clk);
        #1;
        n_vec++;
        chk("rst_ic_req_vld", -1, 32'(ic_req_vld), 32'd0);
        chk("rst_ifid_vld",   -1, 32'(ifid_vld),   32'd0);
        chk("rst_ifid_pc",    -1, ifid_pc,         32'd0);
        chk("rst_ifid_inst",  -1, ifid_inst,       32'd0);
        chk("rst_ifid_err",   -1, 32'(ifid_err),   32'd0);
        chk("rst_fetch_busy", -1, 32'(fetch_busy), 32'd0);
        chk("rst_req_addr",   -1, ic_req_addr,     32'h8000_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(vecs[i].rd, vecs[i].rpc, vecs[i].qrdy, vecs[i].sv, vecs[i].si, vecs[i].se, vecs[i].ir);
            #1;
            n_vec++;
            chk("ic_req_vld",  i, 32'(ic_req_vld), 32'(vecs[i].qv));
            chk("ic_req_addr", i, ic_req_addr,     vecs[i].qa);
            chk("ifid_vld",    i, 32'(ifid_vld),   32'(vecs[i].iv));
            chk("fetch_busy",  i, 32'(fetch_busy), 32'(vecs[i].busy));
            if (vecs[i].iv) begin
                chk("ifid_pc",   i, ifid_pc,        vecs[i].ipc);
                chk("ifid_inst", i, ifid_inst,      vecs[i].iinst);
                chk("ifid_err",  i, 32'(ifid_err),  32'(vecs[i].ierr));
            end
        end

        // Asynchronous reset while a request is outstanding, then a stray response in IDLE.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_vec++;
        chk("pre_rst_busy", 100, 32'(fetch_busy), 32'd1);
        chk("pre_rst_addr", 100, ic_req_addr,     32'h0000_0004);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("async_rst_busy",     101, 32'(fetch_busy), 32'd0);
        chk("async_rst_req_vld",  101, 32'(ic_req_vld), 32'd0);
        chk("async_rst_addr",     101, ic_req_addr,     32'h8000_0000);
        chk("async_rst_ifid_vld", 101, 32'(ifid_vld),   32'd0);
        chk("async_rst_ifid_pc",  101, ifid_pc,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 1, BAD, 1, 1);
        #1;
        n_vec++;
        chk("idle_req_vld",  102, 32'(ic_req_vld), 32'd0);
        chk("idle_ifid_vld", 102, 32'(ifid_vld),   32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_vec++;
        chk("post_rst_req_vld",  103, 32'(ic_req_vld), 32'd1);
        chk("post_rst_addr",     103, ic_req_addr,     32'h8000_0000);
        chk("post_rst_ifid_vld", 103, 32'(ifid_vld),   32'd0);
        chk("post_rst_busy",     103, 32'(fetch_busy), 32'd0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0, 1);
        #1;
        n_vec++;
        chk("post_rst_req_vld2", 104, 32'(ic_req_vld), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_vec++;
        chk("post_rst_wait_busy", 105, 32'(fetch_busy), 32'd1);
        chk("post_rst_wait_addr", 105, ic_req_addr,     32'h8000_0004);
        chk("post_rst_wait_ifid", 105, 32'(ifid_vld),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
